// File: rtl/riscv_v_pkg.sv
// Shared types for the vector execute issue sequencer: element sizes, FSM states,
// vl / element-mask types and the elements-per-register helper.
package riscv_v_pkg;

   localparam int VREG_BYTES    = 16;
   localparam int MAX_LMUL_LOG2 = 3;
   localparam int VL_W          = 8;
   localparam int EPR_W         = $clog2(VREG_BYTES) + 1;
   localparam int BEAT_W        = (MAX_LMUL_LOG2 > 0) ? MAX_LMUL_LOG2 : 1;
   localparam int PROD_W        = VL_W + 1;

   typedef enum logic [1:0] {
      OSIZE_8  = 2'd0,
      OSIZE_16 = 2'd1,
      OSIZE_32 = 2'd2,
      OSIZE_64 = 2'd3
   } riscv_v_osize_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_MUL_WAIT = 2'd2
   } riscv_v_exe_ctrl_state_e;

   typedef logic [VL_W-1:0]       riscv_v_vl_t;
   typedef logic [VREG_BYTES-1:0] riscv_v_elem_mask_t;
   typedef logic [EPR_W-1:0]      riscv_v_epr_t;

   function automatic riscv_v_epr_t riscv_v_epr(input riscv_v_osize_e osize);
      riscv_v_epr_t full;
      full = riscv_v_epr_t'(VREG_BYTES);
      return full >> osize;
   endfunction

endpackage

// File: rtl/riscv_v_exe_ctrl_if.sv
// Request / beat / writeback bundle between the decoder side (master) and the sequencer (slave).
interface riscv_v_exe_ctrl_if;
   import riscv_v_pkg::*;

   logic               req_valid;
   logic               req_ready;
   riscv_v_osize_e     req_osize;
   riscv_v_vl_t        req_vl;
   logic [2:0]         req_lmul_log2;
   logic [4:0]         req_vs1;
   logic [4:0]         req_vs2;
   logic [4:0]         req_vd;
   logic               req_is_mul;
   logic               req_is_reduct;
   logic               wb_ready;
   logic               alu_valid;
   logic [4:0]         alu_vs1;
   logic [4:0]         alu_vs2;
   logic [4:0]         alu_vd;
   riscv_v_osize_e     alu_osize;
   riscv_v_elem_mask_t alu_elem_mask;
   logic               alu_first;
   logic               alu_last;
   logic               wb_valid;
   logic               busy;

   modport master (
      output req_valid, req_osize, req_vl, req_lmul_log2, req_vs1, req_vs2, req_vd,
             req_is_mul, req_is_reduct, wb_ready,
      input  req_ready, alu_valid, alu_vs1, alu_vs2, alu_vd, alu_osize, alu_elem_mask,
             alu_first, alu_last, wb_valid, busy
   );

   modport slave (
      input  req_valid, req_osize, req_vl, req_lmul_log2, req_vs1, req_vs2, req_vd,
             req_is_mul, req_is_reduct, wb_ready,
      output req_ready, alu_valid, alu_vs1, alu_vs2, alu_vd, alu_osize, alu_elem_mask,
             alu_first, alu_last, wb_valid, busy
   );

endinterface

// File: rtl/riscv_v_tail_mask_gen.sv
// Combinational tail mask and last-beat detect for one register-sized beat.
module riscv_v_tail_mask_gen
   import riscv_v_pkg::*;
(
   input  logic [BEAT_W-1:0] beat,
   input  riscv_v_epr_t      epr,
   input  riscv_v_vl_t       vl_eff,
   output riscv_v_elem_mask_t elem_mask,
   output logic              last
);

   logic [PROD_W-1:0] base_s;

   // Element i is live when it exists at this osize and sits below vl_eff.
   always_comb begin
      base_s    = PROD_W'(beat) * PROD_W'(epr);
      elem_mask = '0;
      for (int i = 0; i < VREG_BYTES; i++) begin
         if ((EPR_W'(i) < epr) && ((base_s + PROD_W'(i)) < PROD_W'(vl_eff))) begin
            elem_mask[i] = 1'b1;
         end else begin
            elem_mask[i] = 1'b0;
         end
      end
      last = ((PROD_W'(beat) + PROD_W'(1)) * PROD_W'(epr)) >= PROD_W'(vl_eff);
   end

endmodule

// File: rtl/riscv_v_exe_ctrl.sv
// Vector ALU issue sequencer: splits one instruction into per-register beats.
// Optional perf counters enabled by defining RISCV_V_EXE_CTRL_PERF_EN.
module riscv_v_exe_ctrl
   import riscv_v_pkg::*;
#(
   parameter int MUL_LAT = 2
)(
   input  logic clk,
   input  logic rst,
   riscv_v_exe_ctrl_if.slave bus
`ifdef RISCV_V_EXE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_instr_cnt,
   output logic [31:0] perf_beat_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LAT - 1);

   riscv_v_exe_ctrl_state_e state_q, state_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   riscv_v_epr_t       epr_q, epr_d;
   riscv_v_vl_t        vl_eff_q, vl_eff_d;
   riscv_v_osize_e     osize_q, osize_d;
   logic [4:0]         vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
   logic               is_mul_q, is_mul_d, is_red_q, is_red_d;
   logic               req_ready_q, req_ready_d, busy_q, busy_d, alu_valid_q, alu_valid_d;
   logic [4:0]         alu_vs1_q, alu_vs1_d, alu_vs2_q, alu_vs2_d, alu_vd_q, alu_vd_d;
   riscv_v_osize_e     alu_osize_q, alu_osize_d;
   riscv_v_elem_mask_t mask_q, mask_d, mask_s;
   logic               first_q, first_d, last_q, last_d, last_s, wb_valid_q, wb_valid_d;
   logic               accept_s, advance_s, beat_done_s;
   riscv_v_epr_t       req_epr_s;
   logic [2:0]         lmul_s;
   logic [15:0]        cap_s;
   riscv_v_vl_t        req_vl_eff_s;

   // Outputs are computed from the next beat so they can be registered.
   riscv_v_tail_mask_gen u_mask (
      .beat      (beat_d),
      .epr       (epr_d),
      .vl_eff    (vl_eff_d),
      .elem_mask (mask_s),
      .last      (last_s)
   );

   // Next-state, beat and latched-field update.
   always_comb begin
      state_d = state_q;   beat_d = beat_q;     cnt_d = cnt_q;
      epr_d = epr_q;       vl_eff_d = vl_eff_q; osize_d = osize_q;
      vs1_d = vs1_q;       vs2_d = vs2_q;       vd_d = vd_q;
      is_mul_d = is_mul_q; is_red_d = is_red_q;
      accept_s  = 1'b0;
      advance_s = 1'b0;
      beat_done_s  = !is_mul_q || (cnt_q == LAST_CNT);
      req_epr_s    = riscv_v_epr(bus.req_osize);
      lmul_s       = (bus.req_lmul_log2 > 3'(MAX_LMUL_LOG2)) ? 3'(MAX_LMUL_LOG2) : bus.req_lmul_log2;
      cap_s        = 16'(req_epr_s) << lmul_s;
      req_vl_eff_s = (16'(bus.req_vl) < cap_s) ? bus.req_vl : cap_s[VL_W-1:0];
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               accept_s = 1'b1;
               epr_d    = req_epr_s;
               vl_eff_d = req_vl_eff_s;
               osize_d  = bus.req_osize;
               vs1_d    = bus.req_vs1;
               vs2_d    = bus.req_vs2;
               vd_d     = bus.req_vd;
               is_mul_d = bus.req_is_mul;
               is_red_d = bus.req_is_reduct;
               beat_d   = '0;
               cnt_d    = '0;
               state_d  = (req_vl_eff_s != '0) ? ST_ISSUE : ST_IDLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE, ST_MUL_WAIT: begin
            if (!beat_done_s) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = ST_MUL_WAIT;
            end else if (!wb_valid_q || bus.wb_ready) begin
               advance_s = 1'b1;
               cnt_d     = '0;
               if (last_q) begin
                  state_d = ST_IDLE;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered beat outputs; everything except req_ready is zero while idle.
   always_comb begin
      req_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      alu_valid_d = busy_d;
      if (busy_d) begin
         alu_vs1_d   = vs1_d + 5'(beat_d);
         alu_vs2_d   = vs2_d + 5'(beat_d);
         alu_vd_d    = is_red_d ? vd_d : (vd_d + 5'(beat_d));
         alu_osize_d = osize_d;
         mask_d      = mask_s;
         first_d     = (beat_d == '0);
         last_d      = last_s;
         wb_valid_d  = (!is_mul_d || (cnt_d == LAST_CNT)) && (!is_red_d || last_s);
      end else begin
         alu_vs1_d   = 5'd0;
         alu_vs2_d   = 5'd0;
         alu_vd_d    = 5'd0;
         alu_osize_d = OSIZE_8;
         mask_d      = '0;
         first_d     = 1'b0;
         last_d      = 1'b0;
         wb_valid_d  = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;  beat_q <= '0;      cnt_q <= '0;
         epr_q <= '0;         vl_eff_q <= '0;    osize_q <= OSIZE_8;
         vs1_q <= 5'd0;       vs2_q <= 5'd0;     vd_q <= 5'd0;
         is_mul_q <= 1'b0;    is_red_q <= 1'b0;
         req_ready_q <= 1'b1; busy_q <= 1'b0;    alu_valid_q <= 1'b0;
         alu_vs1_q <= 5'd0;   alu_vs2_q <= 5'd0; alu_vd_q <= 5'd0;
         alu_osize_q <= OSIZE_8; mask_q <= '0;
         first_q <= 1'b0;     last_q <= 1'b0;    wb_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;  beat_q <= beat_d;  cnt_q <= cnt_d;
         epr_q <= epr_d;      vl_eff_q <= vl_eff_d; osize_q <= osize_d;
         vs1_q <= vs1_d;      vs2_q <= vs2_d;    vd_q <= vd_d;
         is_mul_q <= is_mul_d; is_red_q <= is_red_d;
         req_ready_q <= req_ready_d; busy_q <= busy_d; alu_valid_q <= alu_valid_d;
         alu_vs1_q <= alu_vs1_d; alu_vs2_q <= alu_vs2_d; alu_vd_q <= alu_vd_d;
         alu_osize_q <= alu_osize_d; mask_q <= mask_d;
         first_q <= first_d;  last_q <= last_d;  wb_valid_q <= wb_valid_d;
      end
   end

   assign bus.req_ready     = req_ready_q;
   assign bus.busy          = busy_q;
   assign bus.alu_valid     = alu_valid_q;
   assign bus.alu_vs1       = alu_vs1_q;
   assign bus.alu_vs2       = alu_vs2_q;
   assign bus.alu_vd        = alu_vd_q;
   assign bus.alu_osize     = alu_osize_q;
   assign bus.alu_elem_mask = mask_q;
   assign bus.alu_first     = first_q;
   assign bus.alu_last      = last_q;
   assign bus.wb_valid      = wb_valid_q;

`ifdef RISCV_V_EXE_CTRL_PERF_EN
   logic [31:0] perf_instr_q, perf_instr_d, perf_beat_q, perf_beat_d, perf_stall_q, perf_stall_d;

   // Free-running wrap-around event counters.
   always_comb begin
      perf_instr_d = perf_instr_q + (accept_s ? 32'd1 : 32'd0);
      perf_beat_d  = perf_beat_q + (advance_s ? 32'd1 : 32'd0);
      perf_stall_d = perf_stall_q + ((wb_valid_q && !bus.wb_ready) ? 32'd1 : 32'd0);
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_instr_q <= 32'd0;
         perf_beat_q  <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_instr_q <= perf_instr_d;
         perf_beat_q  <= perf_beat_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_instr_cnt = perf_instr_q;
   assign perf_beat_cnt  = perf_beat_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/riscv_v_exe_ctrl.md
Name: riscv_v_exe_ctrl

Overview:
Issue sequencer in front of the vector execute ALU. Accepts one decoded vector ALU instruction per valid/ready handshake and splits it into per-register beats according to vl, osize and LMUL. For each beat it drives register indices, an active-element (tail) mask and first/last markers, holds multiply beats for the multiplier latency, and raises writeback-valid under backpressure.

Parameters:
VREG_BYTES, 16, bytes per vector register (element slots per beat at 8-bit osize).
MAX_LMUL_LOG2, 3, largest register group is 2**3 = 8 registers.
MUL_LAT, 2, cycles a multiply beat occupies the ALU (>=1).
VL_W, 8, width of vl; must hold VREG_BYTES*2**MAX_LMUL_LOG2 = 128.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  instruction offered
req_ready  out  1  controller can accept
req_osize  in  2  riscv_v_osize_e element size: 0=8b, 1=16b, 2=32b, 3=64b
req_vl  in  VL_W  requested vector length in elements
req_lmul_log2  in  3  log2 of register group size (0..MAX_LMUL_LOG2)
req_vs1, req_vs2, req_vd  in  5 each  base register indices
req_is_mul  in  1  multiply-class op
req_is_reduct  in  1  reduction op
wb_ready  in  1  writeback accepts a result this cycle
alu_valid  out  1  beat operands valid for the ALU
alu_vs1, alu_vs2, alu_vd  out  5 each  base + beat index (vd stays at base for reductions)
alu_osize  out  2  latched osize
alu_elem_mask  out  VREG_BYTES  active elements of this beat (bit i = element i)
alu_first, alu_last  out  1 each  first / last beat of the instruction
wb_valid  out  1  result of current beat ready for writeback
busy  out  1  instruction in flight

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; reset mid-instruction aborts it with no further wb_valid.
- States: IDLE, ISSUE, MUL_WAIT.
- IDLE: req_ready=1. On req_valid, latch fields, set beat=0 and compute epr = VREG_BYTES>>osize and vl_eff = min(vl, epr<<lmul_log2). vl_eff==0: accept, stay IDLE, no alu_valid. Otherwise go to ISSUE next cycle.
- ISSUE/MUL_WAIT: req_ready=0, busy=1, alu_valid=1. alu_vsX = base+beat, mod 32 (wrap, no error). alu_elem_mask[i] = (i<epr) && (beat*epr+i < vl_eff). alu_first = (beat==0). alu_last = ((beat+1)*epr >= vl_eff).
- Non-mul: wb_valid=1 in ISSUE (reduction: only when alu_last).
- Mul: on entry to ISSUE start a counter; go to MUL_WAIT and hold beat outputs for MUL_LAT cycles total; wb_valid only on the final cycle (reduction: only on the last beat). MUL_LAT=1 behaves as non-mul.
- Beat advances when the beat is complete and (wb_valid ? wb_ready : 1). wb_valid with wb_ready=0 stalls: all alu_* outputs stable.
- Completion of the last beat: go to IDLE and raise req_ready the next cycle. No back-to-back acceptance in the completion cycle.
- Fields are latched; req_* changes while busy are ignored.

Optional Feature:
RISCV_V_EXE_CTRL_PERF_EN: adds outputs perf_instr_cnt, perf_beat_cnt and perf_stall_cnt (32 bits each, wrap at 2**32, reset 0). They count accepted instructions, completed beats and cycles with wb_valid && !wb_ready. Without the macro these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- riscv_v_pkg holds riscv_v_osize_e, the riscv_v_exe_ctrl_state_e enum, riscv_v_vl_t (VL_W), riscv_v_elem_mask_t (VREG_BYTES) and an epr function (osize -> elements per register).
- One sub-module, riscv_v_tail_mask_gen: combinational, (beat, epr, vl_eff) -> alu_elem_mask, alu_last.

Test Plan:
- osize=2, vl=10, lmul_log2=2, vs1=4, not mul: 3 beats, vs1 = 4,5,6; masks 0x000F, 0x000F, 0x0003; alu_last on beat 3; req_ready back 1 cycle later.
- vl=200, osize=0, lmul_log2=1: vl_eff=32; 2 beats, masks 0xFFFF, 0xFFFF.
- vl=0: accepted, alu_valid never asserts, req_ready stays 1.
- Mul with MUL_LAT=2, osize=3, vl=4, lmul_log2=1: each beat alu_valid for 2 cycles, wb_valid only in the 2nd; 4 cycles total.
- Reduction with osize=1, vl=20, lmul_log2=2: 3 beats, alu_vd constant, wb_valid only on the beat with mask 0x000F.
- wb_ready low for 5 cycles mid-instruction, then rst asserted during a beat: outputs frozen during the stall, then all zero and req_ready=1 after reset.
